// File: rtl/nyan_pkg.sv
// Shared constants and types for the nyan sprite pixel pipeline:
// VGA active size, RGB width, and the 16-entry sprite palette.
package nyan_pkg;

    localparam int RGB_W    = 6;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [RGB_W-1:0] rgb6_t;

    // {r[1:0],g[1:0],b[1:0]}; entry 0 is transparent and never displayed
    localparam rgb6_t PALETTE [0:15] = '{
        6'b00_00_00,  // 0  transparent
        6'b01_01_01,  // 1  dark grey outline
        6'b11_11_11,  // 2  white
        6'b11_10_11,  // 3  pink frosting
        6'b11_01_11,  // 4  magenta sprinkle
        6'b11_00_00,  // 5  red
        6'b11_10_00,  // 6  orange
        6'b11_11_00,  // 7  yellow
        6'b00_11_00,  // 8  green
        6'b00_01_11,  // 9  blue
        6'b10_00_11,  // 10 purple
        6'b10_10_10,  // 11 cat grey
        6'b11_10_10,  // 12 peach pastry
        6'b01_00_01,  // 13 dark purple
        6'b10_01_11,  // 14 violet
        6'b10_11_11   // 15 light cyan
    };

endpackage

// File: rtl/nyan_frame_seq.sv
// Animation frame sequencer: detects the falling edge of vsync, counts
// FRAME_HOLD edges per animation frame and steps frame_idx with wrap.
// With ANIM_PAUSE_EN defined, an anim_pause input freezes the sequencer.
module nyan_frame_seq
    import nyan_pkg::*;
#(
    parameter int FRAMES     = 12,
    parameter int FRAME_HOLD = 5
) (
    input  logic       px_clk,
    input  logic       reset_n,
    input  logic       vsync_in,
`ifdef ANIM_PAUSE_EN
    input  logic       anim_pause,
`endif
    output logic [3:0] frame_idx
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);
    localparam logic [3:0]        LAST_FRAME = 4'(FRAMES - 1);

    logic              vsync_prev;
    logic [HOLD_W-1:0] hold_cnt;
    logic              frame_start;
    logic              advance;

    assign frame_start = vsync_prev && !vsync_in;

`ifdef ANIM_PAUSE_EN
    assign advance = frame_start && !anim_pause;
`else
    assign advance = frame_start;
`endif

    // Edge detector plus hold counter; frame_idx only moves on a vsync edge,
    // so it is stable through the whole visible frame. Edges seen while
    // paused are consumed, not deferred.
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            vsync_prev <= 1'b1;
            hold_cnt   <= '0;
            frame_idx  <= '0;
        end else begin
            vsync_prev <= vsync_in;
            if (advance) begin
                if (hold_cnt == LAST_HOLD) begin
                    hold_cnt  <= '0;
                    frame_idx <= (frame_idx == LAST_FRAME) ? 4'd0 : frame_idx + 4'd1;
                end else begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/nyan_sprite_renderer.sv
// Two-stage pixel pipeline behind the 640x480 sync generator. Stage 0 maps
// the screen coordinate into the scaled sprite window and issues the
// frame-ROM address; stage 1 turns the returned palette index into RGB.
// Syncs travel alongside so rgb/hsync_out/vsync_out share a 2-cycle latency.
// Optional macro ANIM_PAUSE_EN adds an anim_pause input that freezes animation.
module nyan_sprite_renderer
    import nyan_pkg::*;
#(
    parameter int    SPRITE_W    = 64,
    parameter int    SPRITE_H    = 64,
    parameter int    SCALE_SHIFT = 2,
    parameter int    ORIGIN_X    = 192,
    parameter int    ORIGIN_Y    = 112,
    parameter int    FRAMES      = 12,
    parameter int    FRAME_HOLD  = 5,
    parameter rgb6_t BG_RGB      = 6'b00_00_10
) (
    input  logic             px_clk,
    input  logic             reset_n,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             activevideo_in,
    input  logic [9:0]       x_px,
    input  logic [9:0]       y_px,
`ifdef ANIM_PAUSE_EN
    input  logic             anim_pause,
`endif
    output logic [15:0]      rom_addr,
    input  logic [3:0]       rom_data,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [RGB_W-1:0] rgb,
    output logic [3:0]       frame_idx
);

    localparam int SX_W  = $clog2(SPRITE_W);
    localparam int SY_W  = $clog2(SPRITE_H);
    localparam int WIN_W = SPRITE_W << SCALE_SHIFT;
    localparam int WIN_H = SPRITE_H << SCALE_SHIFT;

    // 11-bit bounds so the exclusive end (e.g. 448) never wraps
    localparam logic [10:0] X0 = 11'(ORIGIN_X);
    localparam logic [10:0] X1 = 11'(ORIGIN_X + WIN_W);
    localparam logic [10:0] Y0 = 11'(ORIGIN_Y);
    localparam logic [10:0] Y1 = 11'(ORIGIN_Y + WIN_H);

    localparam logic [15:0] FRAME_SZ = 16'(SPRITE_W * SPRITE_H);
    localparam logic [15:0] ROW_SZ   = 16'(SPRITE_W);

    if (FRAMES * SPRITE_W * SPRITE_H > 65536) begin : g_rom_too_big
        $error("sprite frames do not fit the 16-bit ROM address space");
    end
    if (FRAMES < 1 || FRAMES > 16) begin : g_bad_frames
        $error("FRAMES must be 1..16 to fit the 4-bit frame_idx");
    end
    if (ORIGIN_X + WIN_W > H_ACTIVE || ORIGIN_Y + WIN_H > V_ACTIVE) begin : g_off_screen
        $error("sprite window exceeds the visible area");
    end

    logic              in_x, in_y, in_sprite;
    logic [9:0]        dx, dy;
    logic [SX_W-1:0]   sx;
    logic [SY_W-1:0]   sy;
    logic [15:0]       addr_nxt;
    rgb6_t             rgb_nxt;

    logic in_sprite_d1, active_d1, hsync_d1, vsync_d1;

    nyan_frame_seq #(
        .FRAMES     (FRAMES),
        .FRAME_HOLD (FRAME_HOLD)
    ) u_frame_seq (
        .px_clk     (px_clk),
        .reset_n    (reset_n),
        .vsync_in   (vsync_in),
`ifdef ANIM_PAUSE_EN
        .anim_pause (anim_pause),
`endif
        .frame_idx  (frame_idx)
    );

    assign in_x      = ({1'b0, x_px} >= X0) && ({1'b0, x_px} < X1);
    assign in_y      = ({1'b0, y_px} >= Y0) && ({1'b0, y_px} < Y1);
    assign in_sprite = activevideo_in && in_x && in_y;

    // Offsets are only meaningful inside the window; addr_nxt masks them otherwise
    assign dx = x_px - 10'(ORIGIN_X);
    assign dy = y_px - 10'(ORIGIN_Y);
    assign sx = SX_W'(dx >> SCALE_SHIFT);
    assign sy = SY_W'(dy >> SCALE_SHIFT);

    assign addr_nxt = in_sprite
                    ? 16'(frame_idx) * FRAME_SZ + 16'(sy) * ROW_SZ + 16'(sx)
                    : 16'd0;

    // Palette lookup with index 0 as transparent; blanking forces black
    assign rgb_nxt = !active_d1                           ? '0 :
                     (in_sprite_d1 && rom_data != 4'd0)   ? PALETTE[rom_data] :
                                                            BG_RGB;

    // Stage 0: issue ROM address and carry pixel qualifiers/syncs forward
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            rom_addr     <= '0;
            in_sprite_d1 <= 1'b0;
            active_d1    <= 1'b0;
            hsync_d1     <= 1'b1;
            vsync_d1     <= 1'b1;
        end else begin
            rom_addr     <= addr_nxt;
            in_sprite_d1 <= in_sprite;
            active_d1    <= activevideo_in;
            hsync_d1     <= hsync_in;
            vsync_d1     <= vsync_in;
        end
    end

    // Stage 1: register colour and syncs together for the VGA pins
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            rgb       <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb       <= rgb_nxt;
            hsync_out <= hsync_d1;
            vsync_out <= vsync_d1;
        end
    end

endmodule
